// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - CPU/DMA arbiter for a shared single-port data memory
module mem_bus_arbiter #(
    parameter int DMA_MAX_WAIT = 4,
    parameter int BURST_MAX    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [15:0] stall_cnt
);
    localparam logic [0:0] CPU_OWN = 1'b0;
    localparam logic [0:0] DMA_OWN = 1'b1;

    localparam logic [3:0] WAIT_LAST  = 4'(DMA_MAX_WAIT - 1);
    localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

    logic [0:0] owner;
    logic [3:0] wait_cnt;
    logic [3:0] burst_cnt;
    logic       cpu_busy;
    logic       to_dma;
    logic       to_cpu;

    assign cpu_busy = cpu_rd | cpu_wr;

    // The memory port is muxed purely by owner, so CPU and DMA can never share a cycle.
    always_comb begin
        mem_rd    = cpu_rd;
        mem_wr    = cpu_wr;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;
        cpu_stall = 1'b0;
        dma_gnt   = 1'b0;
        if (owner == DMA_OWN) begin
            mem_rd    = dma_req & ~dma_wr;
            mem_wr    = dma_req & dma_wr;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            cpu_rdata = '0;
            cpu_stall = cpu_busy;
            dma_gnt   = dma_req;
        end
    end

    assign to_dma = (owner == CPU_OWN) && dma_req && (!cpu_busy || (wait_cnt == WAIT_LAST));
    assign to_cpu = (owner == DMA_OWN) && (!dma_req || (dma_gnt && (burst_cnt == BURST_LAST)));

    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= CPU_OWN;
            wait_cnt   <= '0;
            burst_cnt  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
            stall_cnt  <= '0;
        end else begin
            if (to_dma) begin
                owner <= DMA_OWN;
            end else if (to_cpu) begin
                owner <= CPU_OWN;
            end

            // Counts only cycles where the DMA is actually being held off by CPU traffic.
            if ((owner == CPU_OWN) && dma_req && cpu_busy && !to_dma) begin
                wait_cnt <= wait_cnt + 4'd1;
            end else begin
                wait_cnt <= '0;
            end

            if (to_dma) begin
                burst_cnt <= '0;
            end else if (dma_gnt) begin
                burst_cnt <= burst_cnt + 4'd1;
            end

            dma_rvalid <= dma_gnt & ~dma_wr;
            if (dma_gnt && !dma_wr) begin
                dma_rdata <= mem_rdata;
            end

            if (cpu_stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_wr;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_gnt, dma_rvalid;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] stall_cnt;

    logic [31:0] sat_cpu_rdata, sat_dma_rdata, sat_mem_addr, sat_mem_wdata;
    logic        sat_cpu_stall, sat_dma_gnt, sat_dma_rvalid, sat_mem_rd, sat_mem_wr;
    logic [15:0] sat_stall_cnt;
    logic [31:0] sat_mem_rdata = 32'h0;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    logic [31:0] rd_q[$];
    logic [63:0] wr_q[$];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;

    mem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
    );

    // Long-burst configuration so stall saturation is reachable in a short run.
    mem_bus_arbiter #(.DMA_MAX_WAIT(1), .BURST_MAX(15)) dut_sat (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(sat_cpu_rdata), .cpu_stall(sat_cpu_stall),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(sat_dma_gnt), .dma_rvalid(sat_dma_rvalid), .dma_rdata(sat_dma_rdata),
        .mem_rd(sat_mem_rd), .mem_wr(sat_mem_wr), .mem_addr(sat_mem_addr), .mem_wdata(sat_mem_wdata),
        .mem_rdata(sat_mem_rdata), .stall_cnt(sat_stall_cnt)
    );

    task automatic drive_idle();
        cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_wr = 0; dma_addr = 0; dma_wdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        next_cycle();
        drive_idle();
        reset = 1;
        next_cycle();
        next_cycle();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        cpu_rd = 1; cpu_addr = 32'h24;
        @(negedge clk);
        checks++;
        if ({dma_rvalid, dma_gnt, cpu_stall} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got=%b want=000", {dma_rvalid, dma_gnt, cpu_stall});
        end
        checks++;
        if (stall_cnt !== 16'h0 || dma_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_regs stall_cnt=%h dma_rdata=%h want 0", stall_cnt, dma_rdata);
        end
        checks++;
        if ({mem_rd, mem_wr} !== 2'b10 || mem_addr !== 32'h24) begin
            failures++; $display("FAIL reset_passthru rd/wr=%b addr=%h want 10/24", {mem_rd, mem_wr}, mem_addr);
        end
        drive_idle();
    endtask

    task automatic test_idle_grant();
        logic [31:0] exp;
        mem[4] <= 32'hA5A5_0001;
        do_reset();
        rd_q.delete();
        dma_req = 1; dma_wr = 0; dma_addr = 32'h10;
        rd_q.push_back(32'hA5A5_0001);
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b0) begin failures++; $display("FAIL idle_cycle1_gnt got=%b want=0", dma_gnt); end
        next_cycle();
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b1 || mem_addr !== 32'h10 || mem_rd !== 1'b1) begin
            failures++; $display("FAIL idle_cycle2 gnt=%b addr=%h rd=%b want 1/10/1", dma_gnt, mem_addr, mem_rd);
        end
        next_cycle();
        dma_req = 0;
        @(negedge clk);
        checks++;
        if (dma_rvalid !== 1'b1) begin
            failures++; $display("FAIL idle_rvalid got=%b want=1", dma_rvalid);
        end else if (rd_q.size() != 0) begin
            exp = rd_q.pop_front();
            checks++;
            if (dma_rdata !== exp) begin failures++; $display("FAIL idle_rdata got=%h want=%h", dma_rdata, exp); end
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL idle_rvalid_once got=%b want=0", dma_rvalid); end
    endtask

    task automatic test_busy_wait();
        do_reset();
        cpu_rd = 1; cpu_addr = 32'h40;
        dma_req = 1; dma_wr = 0; dma_addr = 32'h80;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({cpu_stall, dma_gnt} !== ((c < 4) ? 2'b00 : 2'b11)) begin
                failures++; $display("FAIL busy_wait_c%0d stall/gnt=%b want=%b", c, {cpu_stall, dma_gnt}, (c < 4) ? 2'b00 : 2'b11);
            end
            next_cycle();
        end
        drive_idle();
    endtask

    task automatic test_back_to_back_burst();
        logic [23:0] gmask;
        logic [63:0] exp;
        logic        got;
        int          w, bad;
        do_reset();
        wr_q.delete();
        gmask = '0; w = 0;
        cpu_wr = 1; cpu_addr = 32'h100; cpu_wdata = 32'h0000_C0DE;
        dma_req = 1; dma_wr = 1; dma_addr = 32'h200; dma_wdata = 32'hD000_0000;
        wr_q.push_back({dma_addr, dma_wdata});
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            got = dma_gnt;
            if (got) begin
                gmask[c] = 1'b1;
                if (wr_q.size() != 0) begin
                    exp = wr_q.pop_front();
                    checks++;
                    if ({mem_addr, mem_wdata} !== exp || mem_wr !== 1'b1) begin
                        failures++; $display("FAIL burst_beat_c%0d got=%h_%h want=%h", c, mem_addr, mem_wdata, exp);
                    end
                end
            end
            if (c == 8) begin
                checks++;
                if (stall_cnt !== 16'd4) begin failures++; $display("FAIL burst_stall_cnt got=%0d want=4", stall_cnt); end
            end
            next_cycle();
            if (got) begin
                w++;
                if (w < 6) begin
                    dma_addr = 32'h200 + 32'(4 * w); dma_wdata = 32'hD000_0000 + 32'(w);
                    wr_q.push_back({dma_addr, dma_wdata});
                end else begin
                    dma_req = 0;
                end
            end
        end
        checks++;
        if (gmask !== 24'h0030F0) begin failures++; $display("FAIL burst_grant_pattern got=%h want=0030f0", gmask); end
        bad = 0;
        for (int i = 0; i < 6; i++) if (mem[128 + i] !== (32'hD000_0000 + 32'(i))) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL burst_mem_image bad_words=%0d want=0", bad); end
        drive_idle();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        dma_req = 1; dma_wr = 0; dma_addr = 32'h20;
        next_cycle();
        next_cycle();
        cpu_wr = 1; cpu_addr = 32'h30; cpu_wdata = 32'h1234;
        reset = 1;
        @(negedge clk);
        checks++;
        if ({dma_gnt, cpu_stall} !== 2'b11) begin
            failures++; $display("FAIL midburst_beat2 gnt/stall=%b want=11", {dma_gnt, cpu_stall});
        end
        next_cycle();
        reset = 0;
        @(negedge clk);
        checks++;
        if ({dma_gnt, cpu_stall, dma_rvalid} !== 3'b000 || stall_cnt !== 16'h0) begin
            failures++; $display("FAIL midburst_after gnt/stall/rvalid=%b stall_cnt=%0d want 000/0", {dma_gnt, cpu_stall, dma_rvalid}, stall_cnt);
        end
        checks++;
        if (mem_wr !== 1'b1 || mem_addr !== 32'h30 || mem_wdata !== 32'h1234) begin
            failures++; $display("FAIL midburst_passthru wr=%b addr=%h data=%h want 1/30/1234", mem_wr, mem_addr, mem_wdata);
        end
        drive_idle();
    endtask

    task automatic test_random_traffic();
        int excl, rd_err, issued, granted, bad;
        logic cpu_pend, dma_pend, cpu_done, dma_done, stop;
        logic [31:0] exp;
        int idx;
        for (int i = 0; i < 256; i++) begin
            mem[i] <= 32'h5A00_0000 | 32'(i);
            ref_mem[i] = 32'h5A00_0000 | 32'(i);
        end
        do_reset();
        rd_q.delete();
        excl = 0; rd_err = 0; issued = 0; granted = 0;
        cpu_pend = 0; dma_pend = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            cpu_done = 0; dma_done = 0;
            if (dma_rvalid) begin
                if (rd_q.size() == 0) rd_err++;
                else begin
                    exp = rd_q.pop_front();
                    if (dma_rdata !== exp) rd_err++;
                end
            end
            if (dma_gnt && (cpu_rd || cpu_wr) && !cpu_stall) excl++;
            if ((cpu_rd || cpu_wr) && !cpu_stall && (dma_gnt || mem_addr !== cpu_addr)) excl++;
            if (dma_gnt && (!dma_req || mem_addr !== dma_addr)) excl++;
            if ((cpu_rd || cpu_wr) && !cpu_stall) begin
                if (cpu_rd && cpu_rdata !== ref_mem[cpu_addr[9:2]]) rd_err++;
                if (cpu_wr) ref_mem[cpu_addr[9:2]] = cpu_wdata;
                cpu_done = 1;
            end
            if (dma_gnt) begin
                granted++;
                if (dma_wr) ref_mem[dma_addr[9:2]] = dma_wdata;
                dma_done = 1;
            end
            next_cycle();
            stop = (cyc >= 2950);
            if (cpu_done || !cpu_pend) begin
                cpu_pend = 0; cpu_rd = 0; cpu_wr = 0;
                if (!stop && $urandom_range(0, 3) != 0) begin
                    idx = $urandom_range(0, 127);
                    cpu_pend = 1;
                    cpu_addr = 32'(idx * 4);
                    cpu_wdata = $urandom;
                    if ($urandom_range(0, 1) == 1) cpu_wr = 1; else cpu_rd = 1;
                end
            end
            if (dma_done || !dma_pend) begin
                dma_pend = 0; dma_req = 0;
                if (!stop && $urandom_range(0, 1) == 1) begin
                    idx = $urandom_range(128, 255);
                    dma_pend = 1; dma_req = 1; issued++;
                    dma_addr = 32'(idx * 4);
                    dma_wdata = $urandom;
                    dma_wr = 1'($urandom_range(0, 1));
                    if (!dma_wr) rd_q.push_back(ref_mem[idx]);
                end
            end
        end
        next_cycle();
        checks++;
        if (excl != 0) begin failures++; $display("FAIL rand_exclusive violations=%0d want=0", excl); end
        checks++;
        if (rd_err != 0) begin failures++; $display("FAIL rand_read_data errors=%0d want=0", rd_err); end
        checks++;
        if (granted != issued || rd_q.size() != 0) begin
            failures++; $display("FAIL rand_dma_count granted=%0d issued=%0d pending_reads=%0d", granted, issued, rd_q.size());
        end
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rand_mem_image bad_words=%0d want=0", bad); end
        drive_idle();
    endtask

    task automatic test_stall_saturate();
        int n, last_chk;
        logic [15:0] exp;
        do_reset();
        cpu_wr = 1; cpu_addr = 32'h3F0; cpu_wdata = 32'h0;
        dma_req = 1; dma_wr = 1; dma_addr = 32'h3F4; dma_wdata = 32'h0;
        n = 0; last_chk = -1;
        for (int cyc = 0; cyc < 72000 && n < 65700; cyc++) begin
            @(negedge clk);
            if (n != last_chk && (n == 1000 || n == 65534 || n == 65535 || n == 65600)) begin
                last_chk = n;
                exp = (n > 65535) ? 16'hFFFF : 16'(n);
                checks++;
                if (sat_stall_cnt !== exp) begin
                    failures++; $display("FAIL sat_count_n%0d got=%h want=%h", n, sat_stall_cnt, exp);
                end
            end
            if (sat_cpu_stall) n++;
            next_cycle();
        end
        checks++;
        if (n < 65700) begin failures++; $display("FAIL sat_budget stalls=%0d want=65700", n); end
        for (int c = 0; c < 50; c++) next_cycle();
        @(negedge clk);
        checks++;
        if (sat_stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h want=ffff", sat_stall_cnt); end
        drive_idle();
    endtask

    initial begin
        reset = 1;
        drive_idle();
        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        test_reset();
        test_idle_grant();
        test_busy_wait();
        test_back_to_back_burst();
        test_reset_mid_burst();
        test_random_traffic();
        test_stall_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
